// File: rtl/led_seq_ctrl.sv
// Command-driven LED bank sequencer: one command at a time runs a rotate, blink or static
// sequence, stepping on an internally generated tick, for a finite step count or until preempted.
module led_seq_ctrl #(
  parameter int unsigned TICK_CYCLES = 62500000,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LED_W-1:0] cmd_pattern,
  input  logic [7:0]       cmd_steps,
  output logic [LED_W-1:0] led_out,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_ROT_R, M_ROT_L, M_BLINK, M_STATIC} mode_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;

  logic             accept;
  logic             strobe;

  // A rotation seeded with all zeros would never show anything, so it gets a single lit LED.
  function automatic logic [LED_W-1:0] init_led(input mode_t m, input logic [LED_W-1:0] p);
    init_led = p;
    if (p == '0) begin
      if (m == M_ROT_R)      init_led = {1'b1, {(LED_W-1){1'b0}}};
      else if (m == M_ROT_L) init_led = {{(LED_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [LED_W-1:0] step_led(input mode_t m, input logic [LED_W-1:0] cur,
                                                input logic [LED_W-1:0] p);
    case (m)
      M_ROT_R: step_led = {cur[0], cur[LED_W-1:1]};
      M_ROT_L: step_led = {cur[LED_W-2:0], cur[LED_W-1]};
      M_BLINK: step_led = (cur == '0) ? p : '0;
      default: step_led = cur;
    endcase
  endfunction

  // Preemption is only possible in an infinite run, i.e. remaining==0 while running.
  assign cmd_ready = (state_q == S_IDLE) || (rem_q == 8'd0);
  assign accept    = cmd_valid && cmd_ready;
  assign strobe    = (state_q == S_RUN) && (cnt_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;

    if (accept) begin
      // A new command overrides any step strobe landing in the same cycle.
      state_d = S_RUN;
      mode_d  = mode_t'(cmd_mode);
      pat_d   = cmd_pattern;
      led_d   = init_led(mode_t'(cmd_mode), cmd_pattern);
      cnt_d   = 32'd0;
      rem_d   = cmd_steps;
      busy_d  = 1'b1;
    end else if (state_q == S_RUN) begin
      cnt_d = strobe ? 32'd0 : cnt_q + 32'd1;
      if (strobe) begin
        led_d  = step_led(mode_q, led_q, pat_q);
        tick_d = 1'b1;
        if (rem_q != 8'd0) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    end else begin
      cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_ROT_R;
      pat_q   <= '0;
      led_q   <= '0;
      cnt_q   <= 32'd0;
      rem_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with a 4-cycle step tick.
module tb_led_seq_ctrl;
  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_pattern;
  logic [7:0] cmd_steps;
  logic [7:0] led_out;
  logic       busy;
  logic       done;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.TICK_CYCLES(TICK), .LED_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_pattern(cmd_pattern),
    .cmd_steps  (cmd_steps),
    .led_out    (led_out),
    .busy       (busy),
    .done       (done),
    .tick       (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] m, input logic [7:0] p, input logic [7:0] s);
    cmd_valid   = 1'b1;
    cmd_mode    = m;
    cmd_pattern = p;
    cmd_steps   = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_pattern = 8'h00; cmd_steps = 8'd0;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL reset led: got %h exp 00", led_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b exp 0", done); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset tick: got %b exp 0", tick); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b exp 1", cmd_ready); end
    $display("reset: led=%h busy=%b ready=%b", led_out, busy, cmd_ready);
  endtask

  task automatic test_rot_r();
    logic [7:0] e_led;
    drive_cmd(2'd0, 8'h01, 8'd3);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      e_led = (c < 5) ? 8'h01 : (c < 9) ? 8'h80 : (c < 13) ? 8'h40 : 8'h20;
      n_cmp++; if (led_out !== e_led) begin n_err++; $display("FAIL rot_r led c%0d: got %h exp %h", c, led_out, e_led); end
      n_cmp++; if (tick !== (c == 5 || c == 9 || c == 13)) begin n_err++; $display("FAIL rot_r tick c%0d: got %b", c, tick); end
      n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL rot_r done c%0d: got %b", c, done); end
      n_cmp++; if (busy !== (c < 13)) begin n_err++; $display("FAIL rot_r busy c%0d: got %b", c, busy); end
      n_cmp++; if (cmd_ready !== (c == 13)) begin n_err++; $display("FAIL rot_r ready c%0d: got %b", c, cmd_ready); end
    end
    $display("rot_r: final led=%h done=%b", led_out, done);
    step();
    n_cmp++; if (led_out !== 8'h20) begin n_err++; $display("FAIL rot_r hold led: got %h exp 20", led_out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rot_r done after: got %b exp 0", done); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rot_r tick after: got %b exp 0", tick); end
  endtask

  task automatic test_rot_l();
    logic [7:0] e_led;
    int done_cnt = 0;
    drive_cmd(2'd1, 8'h00, 8'd2);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      e_led = (c < 5) ? 8'h01 : (c < 9) ? 8'h02 : 8'h04;
      n_cmp++; if (led_out !== e_led) begin n_err++; $display("FAIL rot_l led c%0d: got %h exp %h", c, led_out, e_led); end
      n_cmp++; if (busy !== (c < 9)) begin n_err++; $display("FAIL rot_l busy c%0d: got %b", c, busy); end
      if (done === 1'b1) done_cnt++;
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rot_l done count: got %0d exp 1", done_cnt); end
    $display("rot_l: final led=%h dones=%0d", led_out, done_cnt);
  endtask

  task automatic test_blink_preempt();
    logic [7:0] e_led;
    drive_cmd(2'd2, 8'hA5, 8'd0);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      e_led = (((c - 1) / 4) % 2 == 0) ? 8'hA5 : 8'h00;
      n_cmp++; if (led_out !== e_led) begin n_err++; $display("FAIL blink led c%0d: got %h exp %h", c, led_out, e_led); end
      n_cmp++; if (tick !== (c == 5 || c == 9)) begin n_err++; $display("FAIL blink tick c%0d: got %b", c, tick); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL blink done c%0d: got %b exp 0", c, done); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL blink ready c%0d: got %b exp 1", c, cmd_ready); end
    end
    // Cycle 12 carries the step strobe; the STATIC command lands on it.
    drive_cmd(2'd3, 8'h3C, 8'd0);
    for (int d = 1; d <= 5; d++) begin
      step();
      if (d == 1) cmd_valid = 1'b0;
      n_cmp++; if (led_out !== 8'h3C) begin n_err++; $display("FAIL preempt led d%0d: got %h exp 3c", d, led_out); end
      n_cmp++; if (tick !== (d == 5)) begin n_err++; $display("FAIL preempt tick d%0d: got %b", d, tick); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL preempt busy d%0d: got %b exp 1", d, busy); end
    end
    $display("blink_preempt: led=%h tick=%b", led_out, tick);
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    drive_cmd(2'd0, 8'h0F, 8'd0);
    for (int r = 1; r <= 3; r++) begin
      step();
      n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL midrst led r%0d: got %h exp 00", r, led_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst busy r%0d: got %b exp 0", r, busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst done r%0d: got %b exp 0", r, done); end
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL midrst tick r%0d: got %b exp 0", r, tick); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst ready r%0d: got %b exp 1", r, cmd_ready); end
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_vs_cmd busy: got %b exp 0", busy); end
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL rst_vs_cmd led: got %h exp 00", led_out); end
    $display("reset_mid_run: led=%h busy=%b", led_out, busy);
  endtask

  task automatic test_drop();
    logic [7:0] e_led;
    drive_cmd(2'd0, 8'h01, 8'd3);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      if (c == 3 || c == 9) drive_cmd(2'd2, 8'hFF, 8'd0);
      else cmd_valid = 1'b0;
      e_led = (c < 5) ? 8'h01 : (c < 9) ? 8'h80 : (c < 13) ? 8'h40 : 8'h20;
      n_cmp++; if (led_out !== e_led) begin n_err++; $display("FAIL drop led c%0d: got %h exp %h", c, led_out, e_led); end
      n_cmp++; if (cmd_ready !== (c == 13)) begin n_err++; $display("FAIL drop ready c%0d: got %b", c, cmd_ready); end
      n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL drop done c%0d: got %b", c, done); end
    end
    $display("drop: final led=%h done=%b", led_out, done);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e_led;
    // Still in the done cycle of the previous run: cmd_ready is already 1.
    drive_cmd(2'd1, 8'h81, 8'd1);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) cmd_valid = 1'b0;
      e_led = (c < 5) ? 8'h81 : 8'h03;
      n_cmp++; if (led_out !== e_led) begin n_err++; $display("FAIL b2b led c%0d: got %h exp %h", c, led_out, e_led); end
      n_cmp++; if (done !== (c == 5)) begin n_err++; $display("FAIL b2b done c%0d: got %b", c, done); end
      n_cmp++; if (tick !== (c == 5)) begin n_err++; $display("FAIL b2b tick c%0d: got %b", c, tick); end
      n_cmp++; if (busy !== (c < 5)) begin n_err++; $display("FAIL b2b busy c%0d: got %b", c, busy); end
    end
    step();
    n_cmp++; if (led_out !== 8'h03) begin n_err++; $display("FAIL b2b hold led: got %h exp 03", led_out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b done after: got %b exp 0", done); end
    $display("back_to_back: led=%h busy=%b", led_out, busy);
  endtask

  initial begin
    test_reset();
    test_rot_r();
    test_rot_l();
    test_blink_preempt();
    test_reset_mid_run();
    test_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
